// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and W8 twiddle ROM for the radix-2 butterfly.
package fft_pkg;

    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 8;
    localparam int unsigned FRAC = 7;

    typedef enum logic [2:0] {
        StIdle,
        StMult,
        StAdd,
        StOut0,
        StOut1,
        StOut2,
        StOut3
    } bfly_state_t;

    typedef struct packed {
        logic signed [CW-1:0] re;
        logic signed [CW-1:0] im;
    } twiddle_t;

    // W8^k in Q1.7; +1.0 is clipped to 127 while -1.0 is exact.
    localparam twiddle_t TWIDDLE_ROM [8] = '{
        '{re: 8'sd127,  im: 8'sd0},
        '{re: 8'sd91,   im: -8'sd91},
        '{re: 8'sd0,    im: 8'sh80},
        '{re: -8'sd91,  im: -8'sd91},
        '{re: 8'sh80,   im: 8'sd0},
        '{re: -8'sd91,  im: 8'sd91},
        '{re: 8'sd0,    im: 8'sd127},
        '{re: 8'sd91,   im: 8'sd91}
    };

    localparam logic signed [DW+2:0] SAT_MAX = (DW+3)'(2 ** (DW - 1) - 1);
    localparam logic signed [DW+2:0] SAT_MIN = ~SAT_MAX;

    // Halve an 11-bit sum and clamp to a byte; MSB of the result flags saturation.
    function automatic logic [DW:0] half_sat(input logic signed [DW+2:0] s);
        logic signed [DW+2:0] h;
        h = s >>> 1;
        if (h > SAT_MAX) begin
            return {1'b1, SAT_MAX[DW-1:0]};
        end else if (h < SAT_MIN) begin
            return {1'b1, SAT_MIN[DW-1:0]};
        end
        return {1'b0, h[DW-1:0]};
    endfunction

endpackage

// File: rtl/cmul_w8.sv
// Registered B*W8^k multiplier: products latched on mult_en, rounded sums combinational.
module cmul_w8
    import fft_pkg::*;
(
    input  logic                 clock,
    input  logic                 n_rst,
    input  logic                 mult_en,
    input  logic [2:0]           w,
    input  logic signed [DW-1:0] br,
    input  logic signed [DW-1:0] bi,
    output logic signed [DW+1:0] wbr,
    output logic signed [DW+1:0] wbi
);

    localparam int unsigned PW = DW + CW;
    localparam int unsigned SW = PW + 1;
    localparam logic signed [SW-1:0] HALF = SW'(2 ** (FRAC - 1));

    twiddle_t             tw;
    logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;
    logic signed [SW-1:0] pr, pi;

    assign tw = TWIDDLE_ROM[w];

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            rr_q <= '0;
            ii_q <= '0;
            ri_q <= '0;
            ir_q <= '0;
        end else if (mult_en) begin
            rr_q <= PW'(br) * PW'($signed(tw.re));
            ii_q <= PW'(bi) * PW'($signed(tw.im));
            ri_q <= PW'(br) * PW'($signed(tw.im));
            ir_q <= PW'(bi) * PW'($signed(tw.re));
        end
    end

    always_comb begin
        pr = SW'(rr_q) - SW'(ii_q);
        pi = SW'(ri_q) + SW'(ir_q);
    end

    // Round half up, then drop the Q1.7 fraction; result always fits 10 bits.
    assign wbr = (DW+2)'((pr + HALF) >>> FRAC);
    assign wbi = (DW+2)'((pi + HALF) >>> FRAC);

endmodule

// File: rtl/bfly_serial_out.sv
// Radix-2 DIT butterfly with byte-serial valid/ready output.
// Optional sticky saturation flag port ovf when SAT_FLAG_EN is defined.
module bfly_serial_out
    import fft_pkg::*;
(
    input  logic          clock,
    input  logic          n_rst,
    input  logic          start,
    input  logic [2:0]    w,
    input  logic [DW-1:0] rea,
    input  logic [DW-1:0] ima,
    input  logic [DW-1:0] reb,
    input  logic [DW-1:0] imb,
    output logic          busy,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last
`ifdef SAT_FLAG_EN
    ,
    output logic          ovf
`endif
);

    bfly_state_t          state_q, state_d;
    logic                 cap, mult_en, y_en;
    logic [2:0]           w_q;
    logic signed [DW-1:0] rea_q, ima_q, reb_q, imb_q;
    logic signed [DW-1:0] y0r_q, y0i_q, y1r_q, y1i_q;
    logic signed [DW+1:0] wbr, wbi;
    logic signed [DW+2:0] s0r, s0i, s1r, s1i;
    logic [DW:0]          r0r, r0i, r1r, r1i;

    cmul_w8 u_cmul (
        .clock   (clock),
        .n_rst   (n_rst),
        .mult_en (mult_en),
        .w       (w_q),
        .br      (reb_q),
        .bi      (imb_q),
        .wbr     (wbr),
        .wbi     (wbi)
    );

    always_comb begin
        s0r = (DW+3)'(rea_q) + (DW+3)'(wbr);
        s0i = (DW+3)'(ima_q) + (DW+3)'(wbi);
        s1r = (DW+3)'(rea_q) - (DW+3)'(wbr);
        s1i = (DW+3)'(ima_q) - (DW+3)'(wbi);
        r0r = half_sat(s0r);
        r0i = half_sat(s0i);
        r1r = half_sat(s1r);
        r1i = half_sat(s1i);
    end

    always_comb begin
        state_d    = state_q;
        cap        = 1'b0;
        mult_en    = 1'b0;
        y_en       = 1'b0;
        busy       = 1'b1;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        dout       = '0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    cap     = 1'b1;
                    state_d = StMult;
                end
            end
            StMult: begin
                mult_en = 1'b1;
                state_d = StAdd;
            end
            StAdd: begin
                y_en    = 1'b1;
                state_d = StOut0;
            end
            StOut0: begin
                dout_valid = 1'b1;
                dout       = y0r_q;
                if (dout_ready) state_d = StOut1;
            end
            StOut1: begin
                dout_valid = 1'b1;
                dout       = y0i_q;
                if (dout_ready) state_d = StOut2;
            end
            StOut2: begin
                dout_valid = 1'b1;
                dout       = y1r_q;
                if (dout_ready) state_d = StOut3;
            end
            StOut3: begin
                dout_valid = 1'b1;
                dout_last  = 1'b1;
                dout       = y1i_q;
                if (dout_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            w_q     <= '0;
            rea_q   <= '0;
            ima_q   <= '0;
            reb_q   <= '0;
            imb_q   <= '0;
            y0r_q   <= '0;
            y0i_q   <= '0;
            y1r_q   <= '0;
            y1i_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cap) begin
                w_q   <= w;
                rea_q <= rea;
                ima_q <= ima;
                reb_q <= reb;
                imb_q <= imb;
            end
            if (y_en) begin
                y0r_q <= r0r[DW-1:0];
                y0i_q <= r0i[DW-1:0];
                y1r_q <= r1r[DW-1:0];
                y1i_q <= r1i[DW-1:0];
            end
        end
    end

`ifdef SAT_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            ovf_q <= 1'b0;
        end else if (cap) begin
            ovf_q <= 1'b0;
        end else if (y_en && (r0r[DW] | r0i[DW] | r1r[DW] | r1i[DW])) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_sat;
    assign unused_sat = r0r[DW] | r0i[DW] | r1r[DW] | r1i[DW];
`endif

endmodule

// File: tb/tb_bfly_serial_out.sv
// Scoreboard bench for bfly_serial_out; expected bytes queued at start, checked on acceptance.
module tb_bfly_serial_out;

    logic       clock = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] w = '0;
    logic [7:0] rea = '0, ima = '0, reb = '0, imb = '0;
    logic       busy, dout_valid, dout_last;
    logic       dout_ready = 1'b1;
    logic [7:0] dout;
`ifdef SAT_FLAG_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;
    int nacc   = 0;
    logic [8:0] exp_q[$];

    int tw_re[8] = '{127, 91, 0, -91, -128, -91, 0, 91};
    int tw_im[8] = '{0, -91, -128, -91, 0, 91, 127, 91};

    bfly_serial_out dut (
        .clock      (clock),
        .n_rst      (n_rst),
        .start      (start),
        .w          (w),
        .rea        (rea),
        .ima        (ima),
        .reb        (reb),
        .imb        (imb),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last)
`ifdef SAT_FLAG_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clock = ~clock;

    // Every accepted byte is checked against the head of the scoreboard, including its last flag.
    always @(negedge clock) begin
        if (n_rst && dout_valid && dout_ready) begin
            logic [8:0] e;
            nacc++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte got=%h last=%b", dout, dout_last);
            end else begin
                e = exp_q.pop_front();
                if ({dout_last, dout} !== e) begin
                    errors++;
                    $display("FAIL byte got last=%b data=%h expected last=%b data=%h",
                             dout_last, dout, e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] sat_half(input int s);
        int h;
        h = s >>> 1;
        if (h > 127) h = 127;
        else if (h < -128) h = -128;
        return h[7:0];
    endfunction

    task automatic push_model(input int k, input int ar, input int ai, input int br,
                              input int bi);
        int pr, pi, xr, xi;
        pr = br * tw_re[k] - bi * tw_im[k];
        pi = br * tw_im[k] + bi * tw_re[k];
        xr = (pr + 64) >>> 7;
        xi = (pi + 64) >>> 7;
        exp_q.push_back({1'b0, sat_half(ar + xr)});
        exp_q.push_back({1'b0, sat_half(ai + xi)});
        exp_q.push_back({1'b0, sat_half(ar - xr)});
        exp_q.push_back({1'b1, sat_half(ai - xi)});
    endtask

    task automatic push4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3);
        exp_q.push_back({1'b0, b0});
        exp_q.push_back({1'b0, b1});
        exp_q.push_back({1'b0, b2});
        exp_q.push_back({1'b1, b3});
    endtask

    // Called at posedge+1; returns at posedge+1 of the edge that sampled start.
    task automatic do_start(input logic [2:0] k, input logic [7:0] ar, input logic [7:0] ai,
                            input logic [7:0] br, input logic [7:0] bi);
        w     = k;
        rea   = ar;
        ima   = ai;
        reb   = br;
        imb   = bi;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            if (rnd) dout_ready = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            n++;
        end
        dout_ready = 1'b1;
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL idle_timeout busy=%b pending=%0d expected busy=0 pending=0",
                     busy, exp_q.size());
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({busy, dout_valid, dout_last, dout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b valid=%b last=%b dout=%h expected all 0",
                     busy, dout_valid, dout_last, dout);
        end
`ifdef SAT_FLAG_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got=%b expected=0", ovf);
        end
`endif
        @(posedge clock);
        #1;
        n_rst = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b valid=%b expected 0 0", busy, dout_valid);
        end
    endtask

    task automatic test_identity;
        int cyc = 1;
        push4(8'h14, 8'hF6, 8'hF6, 8'h1E);
        do_start(3'd0, 8'd10, 8'd20, 8'd30, -8'sd40);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got=%b expected=1", busy);
        end
        while (dout_valid !== 1'b1 && cyc < 10) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL latency got=%0d cycles expected=3", cyc);
        end
        wait_idle(20, 1'b0);
    endtask

    task automatic test_twiddle_neg_j;
        push4(8'hF1, 8'hFB, 8'h19, 8'h19);
        do_start(3'd2, 8'd10, 8'd20, 8'd30, -8'sd40);
        wait_idle(20, 1'b0);
    endtask

    task automatic test_saturation;
        push4(8'h7F, 8'h00, 8'hE5, 8'h00);
        do_start(3'd1, 8'd127, 8'd0, 8'd127, 8'd127);
        wait_idle(20, 1'b0);
`ifdef SAT_FLAG_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got=%b expected=1", ovf);
        end
        push4(8'h14, 8'hF6, 8'hF6, 8'h1E);
        do_start(3'd0, 8'd10, 8'd20, 8'd30, -8'sd40);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got=%b expected=0", ovf);
        end
        wait_idle(20, 1'b0);
`endif
    endtask

    task automatic test_backpressure;
        int cyc = 0;
        push4(8'h14, 8'hF6, 8'hF6, 8'h1E);
        do_start(3'd0, 8'd10, 8'd20, 8'd30, -8'sd40);
        while (dout_valid !== 1'b1 && cyc < 10) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        @(posedge clock);
        #1;
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (dout !== 8'hF6 || dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold cycle=%0d got dout=%h valid=%b expected F6 1",
                         i, dout, dout_valid);
            end
        end
        dout_ready = 1'b1;
        wait_idle(20, 1'b0);
    endtask

    task automatic test_ignored_start;
        int cyc = 0;
        push_model(3, -50, 33, 100, -7);
        do_start(3'd3, -8'sd50, 8'd33, 8'd100, -8'sd7);
        do_start(3'd5, 8'd1, 8'd2, 8'd3, 8'd4);
        while (dout_last !== 1'b1 && cyc < 10) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        // Start coincident with acceptance of the last byte must be dropped.
        do_start(3'd6, 8'd77, 8'd66, 8'd55, 8'd44);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_busy got=%b expected=0", busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ignored_start valid=%b busy=%b pending=%0d expected 0 0 0",
                     dout_valid, busy, exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        int base = nacc;
        int cyc  = 0;
        push4(8'h14, 8'hF6, 8'hF6, 8'h1E);
        do_start(3'd0, 8'd10, 8'd20, 8'd30, -8'sd40);
        while (nacc < base + 2 && cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        n_rst = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if ({busy, dout_valid, dout_last, dout} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b valid=%b last=%b dout=%h expected all 0",
                     busy, dout_valid, dout_last, dout);
        end
        @(posedge clock);
        #1;
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (busy !== 1'b0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle busy=%b valid=%b expected 0 0", busy, dout_valid);
        end
        push4(8'hF1, 8'hFB, 8'h19, 8'h19);
        do_start(3'd2, 8'd10, 8'd20, 8'd30, -8'sd40);
        wait_idle(20, 1'b0);
    endtask

    task automatic test_random;
        for (int t = 0; t < 24; t++) begin
            int k, ar, ai, br, bi;
            k  = int'($urandom_range(0, 7));
            ar = int'($urandom_range(0, 255)) - 128;
            ai = int'($urandom_range(0, 255)) - 128;
            br = int'($urandom_range(0, 255)) - 128;
            bi = int'($urandom_range(0, 255)) - 128;
            push_model(k, ar, ai, br, bi);
            do_start(k[2:0], ar[7:0], ai[7:0], br[7:0], bi[7:0]);
            wait_idle(80, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_twiddle_neg_j();
        test_saturation();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
